// File: rtl/deserializer_framed.sv
// Serial-to-parallel framer: captures en-delimited frames, checks preamble and
// optional even parity, and queues packed records behind a valid/ready FIFO.
module deserializer_framed #(
    parameter int                        PRL_DATA_WIDTH = 10,
    parameter int                        PREAMBLE_WIDTH = 4,
    parameter logic [PREAMBLE_WIDTH-1:0] PREAMBLE       = 4'b1010,
    parameter int                        PARITY_EN      = 0,
    parameter int                        BIT_ORDER      = 0,
    parameter int                        FIFO_DEPTH     = 4,
    parameter int                        DROP_CNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_en_i,
    output logic [PRL_DATA_WIDTH-1:0] prl_data_o,
    output logic [PRL_DATA_WIDTH-1:0] prl_data_mask_o,
    output logic [3:0]                prl_err_o,
    output logic                      prl_valid_o,
    input  logic                      prl_ready_i,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);
    localparam int W     = PRL_DATA_WIDTH;
    localparam int BUF_W = W + ((PARITY_EN != 0) ? 1 : 0);
    localparam int CW    = $clog2(BUF_W + 2);
    localparam int PCW   = $clog2(PREAMBLE_WIDTH + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BUF_CNT = CW'(BUF_W);
    localparam logic [CW-1:0] W_CNT   = CW'(W);
    localparam logic [AW:0]   PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, PREAMB, BODY} state_t;

    typedef struct packed {
        logic [W-1:0] data;
        logic [W-1:0] mask;
        logic [3:0]   err;
    } rec_t;

    state_t                    state, state_nxt;
    logic [PCW-1:0]            pre_cnt;
    logic [PREAMBLE_WIDTH-1:0] pre_exp;
    logic                      pre_err;
    logic [CW-1:0]             body_cnt;
    logic [W-1:0]              body_buf;
    logic                      body_xor;

    logic                      frame_end;
    logic [CW-1:0]             n_data;
    logic                      overflow;
    logic [W-1:0]              rec_data, rec_mask;
    logic [3:0]                rec_err;

    rec_t                      mem [FIFO_DEPTH];
    rec_t                      head;
    logic [AW:0]               wr_ptr, rd_ptr;
    logic                      empty, full, pop, wr_en;

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ser_data_en_i) begin
                    if (PREAMBLE_WIDTH == 1) state_nxt = BODY;
                    else                     state_nxt = PREAMB;
                end
            end
            PREAMB: begin
                if (!ser_data_en_i)                             state_nxt = IDLE;
                else if (pre_cnt == PCW'(PREAMBLE_WIDTH - 1))   state_nxt = BODY;
            end
            BODY: begin
                if (!ser_data_en_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Body bits are kept in arrival order (bit i = i-th body bit); the parity
    // bit only contributes to the running XOR, never to the stored data.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pre_cnt  <= '0;
            pre_exp  <= '0;
            pre_err  <= 1'b0;
            body_cnt <= '0;
            body_buf <= '0;
            body_xor <= 1'b0;
        end else if (ser_data_en_i) begin
            if (state == IDLE) begin
                pre_cnt  <= PCW'(1);
                pre_err  <= (ser_data_i != PREAMBLE[PREAMBLE_WIDTH-1]);
                pre_exp  <= PREAMBLE << 1;
                body_cnt <= '0;
                body_buf <= '0;
                body_xor <= 1'b0;
            end else if (state == PREAMB) begin
                pre_cnt  <= pre_cnt + PCW'(1);
                pre_err  <= pre_err | (ser_data_i != pre_exp[PREAMBLE_WIDTH-1]);
                pre_exp  <= pre_exp << 1;
            end else begin
                if (body_cnt < W_CNT)    body_buf <= body_buf | (W'(ser_data_i) << body_cnt);
                if (body_cnt <= BUF_CNT) body_cnt <= body_cnt + CW'(1);
                body_xor <= body_xor ^ ser_data_i;
            end
        end
    end

    assign frame_end = (state != IDLE) && !ser_data_en_i;

    // NOTE: every variable written here gets a default first, so no latches.
    always_comb begin
        n_data = body_cnt;
        if ((PARITY_EN != 0) && (body_cnt != '0)) n_data = body_cnt - CW'(1);
        overflow = (body_cnt > BUF_CNT);
        rec_data = '0;
        rec_mask = '0;
        rec_err  = '0;
        for (int i = 0; i < W; i++) begin
            if (overflow || (CW'(i) < n_data)) begin
                if (BIT_ORDER != 0) begin
                    rec_mask[i] = 1'b1;
                    rec_data[i] = body_buf[i];
                end else begin
                    rec_mask[W-1-i] = 1'b1;
                    rec_data[W-1-i] = body_buf[i];
                end
            end
        end
        if (state == PREAMB) begin
            rec_err  = {1'b1, 2'b00, pre_err};
            rec_data = '0;
            rec_mask = '0;
        end else if (pre_err) begin
            rec_err  = 4'b0001;
            rec_data = '0;
            rec_mask = '0;
        end else if (n_data == '0) begin
            rec_err  = 4'b1000;
            rec_data = '0;
            rec_mask = '0;
        end else if (overflow) begin
            rec_err  = 4'b0010;
        end else begin
            rec_err[2] = (PARITY_EN != 0) && body_xor;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && prl_ready_i;
    assign wr_en = frame_end && (!full || pop);

    // NOTE: the storage array is not reset; outputs are gated by empty instead.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {rec_data, rec_mask, rec_err};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            if (frame_end && full && !pop && (drop_cnt_o != '1))
                drop_cnt_o <= drop_cnt_o + DROP_CNT_WIDTH'(1);
        end
    end

    assign head            = mem[rd_ptr[AW-1:0]];
    assign prl_valid_o     = !empty;
    assign prl_data_o      = empty ? '0 : head.data;
    assign prl_data_mask_o = empty ? '0 : head.mask;
    assign prl_err_o       = empty ? '0 : head.err;

endmodule
